// File: rtl/traffic_phase_sequencer.sv
// Two-road intersection phase controller. Drives an external count-down interval timer,
// inserts an optional pedestrian walk phase and latches a fault if the timer goes dead.
module traffic_phase_sequencer #(
  parameter logic [6:0] T_GREEN_MAIN = 7'd40,
  parameter logic [6:0] T_YELLOW     = 7'd6,
  parameter logic [6:0] T_ALL_RED    = 7'd2,
  parameter logic [6:0] T_GREEN_SIDE = 7'd25,
  parameter logic [6:0] T_WALK       = 7'd15,
  parameter logic [7:0] WD_MARGIN    = 8'd8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       trigger,
  input  logic [6:0] time_remaining,
  input  logic       ped_req,
  output logic [6:0] timer_ref,
  output logic       timer_rst,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk,
  output logic [2:0] phase,
  output logic       ped_pending,
  output logic [6:0] seconds_left,
  output logic       fault
);

  typedef enum logic [2:0] {
    GREEN_MAIN  = 3'd0,
    YELLOW_MAIN = 3'd1,
    ALL_RED_A   = 3'd2,
    GREEN_SIDE  = 3'd3,
    YELLOW_SIDE = 3'd4,
    ALL_RED_B   = 3'd5,
    WALK        = 3'd6,
    FAULT       = 3'd7
  } state_t;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  state_t     state_q, state_d;
  logic [6:0] timer_ref_q, timer_ref_d;
  logic       timer_rst_q, timer_rst_d;
  logic       ped_pending_q, ped_pending_d;
  logic [6:0] seconds_left_q, seconds_left_d;
  logic       fault_q, fault_d;
  logic [7:0] wd_q, wd_d;

  logic [6:0] cur_dur_s;
  state_t     nxt_s;
  logic       advance_s;
  logic [8:0] wd_limit_s;
  logic       wd_trip_s;

  function automatic logic [6:0] duration_of(input state_t s);
    case (s)
      GREEN_MAIN:  duration_of = T_GREEN_MAIN;
      YELLOW_MAIN: duration_of = T_YELLOW;
      ALL_RED_A:   duration_of = T_ALL_RED;
      GREEN_SIDE:  duration_of = T_GREEN_SIDE;
      YELLOW_SIDE: duration_of = T_YELLOW;
      ALL_RED_B:   duration_of = T_ALL_RED;
      WALK:        duration_of = T_WALK;
      default:     duration_of = 7'd0;
    endcase
  endfunction

  // The walk phase is only inserted after the side road has cleared.
  function automatic state_t next_of(input state_t s, input logic ped);
    case (s)
      GREEN_MAIN:  next_of = YELLOW_MAIN;
      YELLOW_MAIN: next_of = ALL_RED_A;
      ALL_RED_A:   next_of = GREEN_SIDE;
      GREEN_SIDE:  next_of = YELLOW_SIDE;
      YELLOW_SIDE: next_of = ALL_RED_B;
      ALL_RED_B:   next_of = ped ? WALK : GREEN_MAIN;
      WALK:        next_of = GREEN_MAIN;
      default:     next_of = FAULT;
    endcase
  endfunction

  assign cur_dur_s  = duration_of(state_q);
  assign nxt_s      = next_of(state_q, ped_pending_q);
  assign advance_s  = trigger & ~timer_rst_q & (state_q != FAULT);
  assign wd_limit_s = {2'b00, cur_dur_s} + 9'd3 + {1'b0, WD_MARGIN};
  assign wd_trip_s  = ({1'b0, wd_q} > wd_limit_s);

  // Next-state, timer handshake and watchdog; an advance beats a watchdog trip.
  always_comb begin
    state_d        = state_q;
    timer_ref_d    = timer_ref_q;
    timer_rst_d    = timer_rst_q;
    fault_d        = fault_q;
    wd_d           = wd_q;
    ped_pending_d  = ped_pending_q;
    seconds_left_d = seconds_left_q;

    if (state_q == FAULT) begin
      timer_rst_d = 1'b1;
    end else if (advance_s) begin
      state_d     = nxt_s;
      timer_ref_d = duration_of(nxt_s);
      timer_rst_d = 1'b1;
      wd_d        = 8'd0;
    end else if (wd_trip_s) begin
      state_d     = FAULT;
      fault_d     = 1'b1;
      timer_rst_d = 1'b1;
    end else begin
      timer_rst_d = 1'b0;
      wd_d        = (wd_q == 8'hFF) ? wd_q : wd_q + 8'd1;
    end

    // A request arriving on the walk-entry edge must survive the clear.
    ped_pending_d  = ped_req | (ped_pending_q & ~(advance_s & (nxt_s == WALK)));
    seconds_left_d = timer_rst_q ? cur_dur_s : time_remaining;
  end

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= GREEN_MAIN;
      timer_ref_q    <= T_GREEN_MAIN;
      timer_rst_q    <= 1'b1;
      ped_pending_q  <= 1'b0;
      seconds_left_q <= T_GREEN_MAIN;
      fault_q        <= 1'b0;
      wd_q           <= 8'd0;
    end else begin
      state_q        <= state_d;
      timer_ref_q    <= timer_ref_d;
      timer_rst_q    <= timer_rst_d;
      ped_pending_q  <= ped_pending_d;
      seconds_left_q <= seconds_left_d;
      fault_q        <= fault_d;
      wd_q           <= wd_d;
    end
  end

  // Lamp decode straight from the phase.
  always_comb begin
    main_light = LAMP_RED;
    side_light = LAMP_RED;
    walk       = 1'b0;
    case (state_q)
      GREEN_MAIN:  main_light = LAMP_GREEN;
      YELLOW_MAIN: main_light = LAMP_YELLOW;
      GREEN_SIDE:  side_light = LAMP_GREEN;
      YELLOW_SIDE: side_light = LAMP_YELLOW;
      WALK:        walk       = 1'b1;
      default:     walk       = 1'b0;
    endcase
  end

  assign phase        = state_q;
  assign timer_ref    = timer_ref_q;
  assign timer_rst    = timer_rst_q;
  assign ped_pending  = ped_pending_q;
  assign seconds_left = seconds_left_q;
  assign fault        = fault_q;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Scoreboard bench for traffic_phase_sequencer: a phase-level reference model predicts every
// cycle's outputs into a queue, a monitor pops and compares on the falling clock edge.
module tb_traffic_phase_sequencer;

  logic       clock;
  logic       reset;
  logic       trigger;
  logic [6:0] time_remaining;
  logic       ped_req;
  logic [6:0] timer_ref;
  logic       timer_rst;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic       walk;
  logic [2:0] phase;
  logic       ped_pending;
  logic [6:0] seconds_left;
  logic       fault;

  logic       dead;
  logic       force_trig;
  logic [6:0] tcnt;
  logic       ttrg;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    int phase;
    int cyc;
    int ped;
  } model_t;

  typedef struct {
    int phase;
    int trst;
    int ped;
    int slc;
    int slc_chk;
    int tref_chk;
  } exp_t;

  exp_t exp_q[$];

  traffic_phase_sequencer #(
    .T_GREEN_MAIN(7'd5),
    .T_YELLOW    (7'd2),
    .T_ALL_RED   (7'd1),
    .T_GREEN_SIDE(7'd4),
    .T_WALK      (7'd3),
    .WD_MARGIN   (8'd8)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .trigger       (trigger),
    .time_remaining(time_remaining),
    .ped_req       (ped_req),
    .timer_ref     (timer_ref),
    .timer_rst     (timer_rst),
    .main_light    (main_light),
    .side_light    (side_light),
    .walk          (walk),
    .phase         (phase),
    .ped_pending   (ped_pending),
    .seconds_left  (seconds_left),
    .fault         (fault)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Team interval timer: load on reset, count down to 0, then one registered trigger pulse.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      tcnt <= 7'd0;
      ttrg <= 1'b0;
    end else if (timer_rst) begin
      tcnt <= timer_ref;
      ttrg <= 1'b0;
    end else if (tcnt != 7'd0) begin
      tcnt <= tcnt - 7'd1;
      ttrg <= 1'b0;
    end else begin
      ttrg <= ~ttrg;
    end
  end

  assign trigger        = force_trig | (~dead & ttrg);
  assign time_remaining = dead ? 7'd0 : tcnt;

  function automatic int dur(input int p);
    case (p)
      0: return 5;
      1: return 2;
      2: return 1;
      3: return 4;
      4: return 2;
      5: return 1;
      6: return 3;
      default: return 0;
    endcase
  endfunction

  function automatic int main_exp(input int p);
    if (p == 0) return 1;
    else if (p == 1) return 2;
    else return 4;
  endfunction

  function automatic int side_exp(input int p);
    if (p == 3) return 1;
    else if (p == 4) return 2;
    else return 4;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
  endtask

  // Each phase lasts duration+3 cycles; the count since entry doubles as the watchdog.
  initial begin : model
    model_t m;
    exp_t   e;
    int     nxt;
    int     into_walk;
    int     tr;
    m = '{0, 0, 0};
    forever begin
      @(posedge clock or posedge reset);
      if (reset) begin
        m = '{0, 0, 0};
        exp_q.delete();
      end else begin
        tr = dur(m.phase) - m.cyc + 1;
        e.slc_chk = (m.phase != 7) ? 1 : 0;
        if (m.cyc == 0) e.slc = dur(m.phase);
        else if (dead) e.slc = 0;
        else e.slc = (tr > 0) ? tr : 0;
        into_walk = 0;
        if (m.phase == 7) begin
          m.cyc++;
        end else if (!dead && m.cyc == dur(m.phase) + 2) begin
          if (m.phase == 5) nxt = (m.ped != 0) ? 6 : 0;
          else if (m.phase == 6) nxt = 0;
          else nxt = m.phase + 1;
          into_walk = (nxt == 6) ? 1 : 0;
          m.phase = nxt;
          m.cyc = 0;
        end else if (m.cyc > dur(m.phase) + 3 + 8) begin
          m.phase = 7;
          m.cyc = 0;
        end else begin
          m.cyc++;
        end
        m.ped = (ped_req || (m.ped != 0 && into_walk == 0)) ? 1 : 0;
        e.phase    = m.phase;
        e.trst     = (m.cyc == 0 || m.phase == 7) ? 1 : 0;
        e.ped      = m.ped;
        e.tref_chk = (m.phase != 7) ? 1 : 0;
        exp_q.push_back(e);
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("phase", int'(phase), e.phase);
        chk("timer_rst", int'(timer_rst), e.trst);
        chk("ped_pending", int'(ped_pending), e.ped);
        chk("fault", int'(fault), (e.phase == 7) ? 1 : 0);
        chk("walk", int'(walk), (e.phase == 6) ? 1 : 0);
        chk("main_light", int'(main_light), main_exp(e.phase));
        chk("side_light", int'(side_light), side_exp(e.phase));
        if (e.tref_chk != 0) chk("timer_ref", int'(timer_ref), dur(e.phase));
        if (e.slc_chk != 0) chk("seconds_left", int'(seconds_left), e.slc);
      end
    end
  end

  task automatic wait_phase(input int p, input int budget);
    int n;
    n = 0;
    while (int'(phase) != p && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk("wait_phase", int'(phase), p);
  endtask

  task automatic chk_reset_values();
    chk("rst_phase", int'(phase), 0);
    chk("rst_walk", int'(walk), 0);
    chk("rst_ped_pending", int'(ped_pending), 0);
    chk("rst_timer_ref", int'(timer_ref), 5);
    chk("rst_timer_rst", int'(timer_rst), 1);
    chk("rst_seconds_left", int'(seconds_left), 5);
    chk("rst_fault", int'(fault), 0);
    chk("rst_main_light", int'(main_light), 1);
  endtask

  initial begin
    reset = 1'b1;
    ped_req = 1'b0;
    dead = 1'b0;
    force_trig = 1'b0;
    repeat (3) @(negedge clock);
    chk_reset_values();
    reset = 1'b0;

    // Plain cycle with no pedestrians.
    repeat (70) @(negedge clock);

    // Single-cycle request during GREEN_SIDE.
    wait_phase(3, 80);
    ped_req = 1'b1;
    @(negedge clock);
    ped_req = 1'b0;
    repeat (40) @(negedge clock);

    // Request held across the walk-entry edge stays pending for the next round.
    wait_phase(5, 80);
    ped_req = 1'b1;
    wait_phase(6, 20);
    @(negedge clock);
    ped_req = 1'b0;
    repeat (50) @(negedge clock);

    // Random request traffic.
    repeat (300) begin
      @(negedge clock);
      ped_req = ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0;
    end
    ped_req = 1'b0;

    // Asynchronous reset in the middle of WALK with a request pending.
    @(negedge clock);
    ped_req = 1'b1;
    @(negedge clock);
    ped_req = 1'b0;
    wait_phase(6, 80);
    ped_req = 1'b1;
    @(negedge clock);
    ped_req = 1'b0;
    @(negedge clock);
    chk("pre_reset_ped_pending", int'(ped_pending), 1);
    chk("pre_reset_walk", int'(walk), 1);
    #2 reset = 1'b1;
    #1 chk_reset_values();

    // Dead timer from reset: watchdog trips, later triggers are ignored.
    @(negedge clock);
    dead = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    repeat (25) @(negedge clock);
    chk("dead_fault", int'(fault), 1);
    force_trig = 1'b1;
    repeat (3) @(negedge clock);
    force_trig = 1'b0;
    repeat (4) @(negedge clock);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/traffic_phase_sequencer.md
Name: traffic_phase_sequencer

Overview:
- Phase controller that drives an external 7-bit interval timer (ref input, reset input, one-cycle trigger output, time-remaining output) and steps a two-road intersection through its light phases, with an optional pedestrian walk phase.
- The timer is the responder. This block is the initiator: it loads the phase duration, resynchronises the timer on every phase change, and advances on each trigger.
- It also runs a watchdog that detects a dead timer.

Parameters:
- T_GREEN_MAIN, 7'd40, timer ref loaded for GREEN_MAIN
- T_YELLOW, 7'd6, timer ref for YELLOW_MAIN and YELLOW_SIDE
- T_ALL_RED, 7'd2, timer ref for ALL_RED_A and ALL_RED_B
- T_GREEN_SIDE, 7'd25, timer ref for GREEN_SIDE
- T_WALK, 7'd15, timer ref for WALK
- WD_MARGIN, 8'd8, extra cycles beyond the expected phase length before a fault is declared

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high
- trigger  input  1  timer expiry pulse
- time_remaining  input  7  timer count-down value
- ped_req  input  1  pedestrian request, level or pulse
- timer_ref  output  7  duration for the current phase
- timer_rst  output  1  registered reset to the timer
- main_light  output  3  {red, yellow, green}, one-hot
- side_light  output  3  {red, yellow, green}, one-hot
- walk  output  1  walk lamp
- phase  output  3  state encoding
- ped_pending  output  1  latched pedestrian request
- seconds_left  output  7  registered display value
- fault  output  1  sticky watchdog fault

Behaviour:
- State encoding:
  - GREEN_MAIN=0, YELLOW_MAIN=1, ALL_RED_A=2, GREEN_SIDE=3, YELLOW_SIDE=4, ALL_RED_B=5, WALK=6, FAULT=7.
  - phase output equals the state encoding.
- Light decode, combinational from state:
  - main_light is green in 0, yellow in 1, red otherwise.
  - side_light is green in 3, yellow in 4, red otherwise.
  - walk=1 only in WALK.
  - FAULT drives both roads red and walk=0.
- Reset values:
  - state=GREEN_MAIN, timer_ref=T_GREEN_MAIN, timer_rst=1.
  - ped_pending=0, seconds_left=T_GREEN_MAIN, fault=0, watchdog counter=0.
- After reset, timer_rst deasserts on the first clock edge after reset release.
- Advance rule:
  - Applies when trigger=1 and timer_rst=0 at a clock edge, in any non-FAULT state.
  - state <= next; timer_ref <= duration(next); timer_rst <= 1 for exactly one cycle; watchdog <= 0.
  - A trigger seen while timer_rst=1 is ignored.
- Transitions:
  - 0→1→2→3→4→5.
  - 5→6 if ped_pending=1, else 5→0.
  - 6→0.
  - FAULT is absorbing until reset.
- Phase length, measured state change to state change with the team Timer attached, is duration+3 cycles:
  - 1 cycle with timer_rst high.
  - duration+1 cycles of counting.
  - 1 cycle of trigger registration.
  - This also holds for duration=0, giving 3 cycles.
- ped_pending:
  - Set when ped_req=1.
  - Cleared on the edge that enters WALK.
  - If ped_req=1 on that same edge, set wins and ped_pending remains 1.
  - Requests during WALK stay pending for the next cycle of phases.
- seconds_left <= duration of the current phase while timer_rst=1, else <= time_remaining. Latency is 1 cycle.
- Watchdog:
  - 8-bit counter, increments every cycle in non-FAULT states and saturates at 255.
  - Cleared on every advance.
  - If the counter exceeds duration(current)+3+WD_MARGIN (computed in 9 bits, no wrap): state <= FAULT, fault <= 1.
  - In FAULT, timer_rst is held at 1 and trigger is ignored.
- Mid-operation reset returns everything to the reset values immediately, including a pending walk and fault.

Test Plan:
- Setup for all scenarios: team Timer attached; parameters G_MAIN=5, Y=2, R=1, G_SIDE=4, WALK=3, WD_MARGIN=8.
- Reset release, ped_req=0 → phase sequence 0,1,2,3,4,5,0 with dwell 8,5,4,7,5,4 cycles; timer_rst high exactly 1 cycle at each change; lights one-hot throughout.
- ped_req pulse (1 cycle) during GREEN_SIDE → ped_pending=1 on next edge; after ALL_RED_B, phase=6, walk=1 for 6 cycles, ped_pending cleared on WALK entry, then phase=0.
- ped_req held high across the WALK entry edge → ped_pending stays 1; the next round also enters WALK.
- Timer disconnected (trigger tied 0) from reset → fault=1 and phase=7 once watchdog exceeds 5+3+8=16, i.e. at the 17th cycle of GREEN_MAIN; both lights red; a later trigger=1 is ignored.
- Assert reset in the middle of WALK with ped_pending=1 → asynchronously phase=0, walk=0, ped_pending=0, timer_ref=5, timer_rst=1, seconds_left=5.
- Check seconds_left tracks time_remaining with 1-cycle lag, e.g. GREEN_MAIN shows 5 during the timer_rst cycle, then 5,5,4,3,2,1.
